// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns hazard, memory-busy and branch-redirect requests into
// per-stage pipeline register controls (PC enable, IF/ID enable/flush, ID/EX
// bubble, EX/MEM enable). A small FSM remembers multi-cycle memory waits,
// the post-redirect squash window and branches that arrived during a freeze.
// A saturating counter records how many cycles the PC was held.
module pipe_stall_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             hdu_stall_in,
    input  logic             mem_busy_in,
    input  logic             branch_taken_in,
    output logic             pc_en_out,
    output logic             if_id_en_out,
    output logic             if_id_flush_out,
    output logic             id_ex_bubble_out,
    output logic             ex_mem_en_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic             err_out
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    // Which request wins this cycle, after priority resolution.
    typedef enum logic [2:0] {
        ACT_IDLE   = 3'd0,
        ACT_BUSY   = 3'd1,
        ACT_BRANCH = 3'd2,
        ACT_SQUASH = 3'd3,
        ACT_STALL  = 3'd4
    } action_t;

    // Squash counter is 3 bits wide since FLUSH_DEPTH is limited to 1..7.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [2:0]       flush_cnt;
    logic [2:0]       flush_cnt_next;
    logic             branch_pending;
    logic             branch_pending_next;
    logic             err;
    logic             err_next;
    logic [CNT_W-1:0] stall_cnt;
    action_t          action;

    logic branch_req;
    logic squash_req;

    // A branch is either arriving now or was deferred while memory was busy.
    assign branch_req = branch_taken_in | branch_pending;

    // A non-zero squash counter means squash cycles are still owed, even if a
    // memory wait interrupted the FLUSH state.
    assign squash_req = (flush_cnt != 3'd0);

    // Resolve competing requests: memory busy, branch, squash, load-use stall.
    always_comb begin
        action = ACT_IDLE;
        if (mem_busy_in) begin
            action = ACT_BUSY;
        end else if (branch_req) begin
            action = ACT_BRANCH;
        end else if (squash_req) begin
            action = ACT_SQUASH;
        end else if (hdu_stall_in) begin
            action = ACT_STALL;
        end
    end

    // State register together with the squash counter, pending branch and error flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= RUN;
            flush_cnt      <= 3'd0;
            branch_pending <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_next;
            flush_cnt      <= flush_cnt_next;
            branch_pending <= branch_pending_next;
            err            <= err_next;
        end
    end

    // Next-state logic driven by the resolved action.
    always_comb begin
        state_next          = RUN;
        flush_cnt_next      = flush_cnt;
        branch_pending_next = branch_pending;
        err_next            = err;
        unique case (action)
            ACT_BUSY: begin
                // Freeze everything; remember a redirect that cannot be taken yet.
                state_next = MEM_WAIT;
                if (branch_taken_in) begin
                    branch_pending_next = 1'b1;
                end
            end
            ACT_BRANCH: begin
                branch_pending_next = 1'b0;
                if (FLUSH_DEPTH > 1) begin
                    flush_cnt_next = FLUSH_RELOAD;
                    state_next     = FLUSH;
                end else begin
                    flush_cnt_next = 3'd0;
                    state_next     = RUN;
                end
            end
            ACT_SQUASH: begin
                flush_cnt_next = flush_cnt - 3'd1;
                state_next     = (flush_cnt == 3'd1) ? RUN : FLUSH;
            end
            ACT_STALL: begin
                // A load-use stall should never need a second cycle.
                if (state == LOAD_STALL) begin
                    err_next = 1'b1;
                end
                state_next = LOAD_STALL;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Pipeline register controls, combinational so a stall takes effect in the same cycle.
    always_comb begin
        pc_en_out        = 1'b1;
        if_id_en_out     = 1'b1;
        if_id_flush_out  = 1'b0;
        id_ex_bubble_out = 1'b0;
        ex_mem_en_out    = 1'b1;
        if (!rst_n_in) begin
            pc_en_out        = 1'b0;
            if_id_en_out     = 1'b0;
            if_id_flush_out  = 1'b1;
            id_ex_bubble_out = 1'b1;
            ex_mem_en_out    = 1'b0;
        end else begin
            unique case (action)
                ACT_BUSY: begin
                    pc_en_out     = 1'b0;
                    if_id_en_out  = 1'b0;
                    ex_mem_en_out = 1'b0;
                end
                ACT_BRANCH: begin
                    if_id_flush_out  = 1'b1;
                    id_ex_bubble_out = 1'b1;
                end
                ACT_SQUASH: begin
                    if_id_flush_out = 1'b1;
                end
                ACT_STALL: begin
                    pc_en_out        = 1'b0;
                    if_id_en_out     = 1'b0;
                    id_ex_bubble_out = 1'b1;
                end
                default: begin
                    pc_en_out = 1'b1;
                end
            endcase
        end
    end

    // Count cycles in which the PC was held, stopping at the maximum value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt <= '0;
        end else if (!pc_en_out && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign state_out     = state;
    assign stall_cnt_out = stall_cnt;
    assign err_out       = err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the stall controller.
module tb_pipe_stall_ctrl;

    localparam int FLUSH_DEPTH = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = 15;

    // Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en}
    localparam logic [4:0] C_DEF  = 5'b11001;
    localparam logic [4:0] C_RST  = 5'b00110;
    localparam logic [4:0] C_HDU  = 5'b00011;
    localparam logic [4:0] C_BUSY = 5'b00000;
    localparam logic [4:0] C_BR   = 5'b11111;
    localparam logic [4:0] C_FL   = 5'b11101;

    logic             clk_in;
    logic             rst_n_in;
    logic             hdu_stall_in;
    logic             mem_busy_in;
    logic             branch_taken_in;
    logic             pc_en_out;
    logic             if_id_en_out;
    logic             if_id_flush_out;
    logic             id_ex_bubble_out;
    logic             ex_mem_en_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_cnt_out;
    logic             err_out;
    logic [4:0]       ctl;

    int checks;
    int failures;

    pipe_stall_ctrl #(
        .FLUSH_DEPTH(FLUSH_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .hdu_stall_in    (hdu_stall_in),
        .mem_busy_in     (mem_busy_in),
        .branch_taken_in (branch_taken_in),
        .pc_en_out       (pc_en_out),
        .if_id_en_out    (if_id_en_out),
        .if_id_flush_out (if_id_flush_out),
        .id_ex_bubble_out(id_ex_bubble_out),
        .ex_mem_en_out   (ex_mem_en_out),
        .state_out       (state_out),
        .stall_cnt_out   (stall_cnt_out),
        .err_out         (err_out)
    );

    assign ctl = {pc_en_out, if_id_en_out, if_id_flush_out, id_ex_bubble_out, ex_mem_en_out};

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic drive(input logic busy, input logic br, input logic hdu);
        mem_busy_in     = busy;
        branch_taken_in = br;
        hdu_stall_in    = hdu;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #3;
        checks++;
        if ({ctl, state_out, stall_cnt_out, err_out} !== {C_RST, 2'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_held: got ctl=%b st=%0d cnt=%0d err=%b, expected ctl=%b st=0 cnt=0 err=0",
                     ctl, state_out, stall_cnt_out, err_out, C_RST);
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (stall_cnt_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_no_count: got cnt=%0d expected 0", stall_cnt_out);
        end
        rst_n_in = 1'b1;
        next_cycle();
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, stall_cnt_out, err_out} !== {C_DEF, 2'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release: got ctl=%b st=%0d cnt=%0d err=%b, expected ctl=%b st=0 cnt=0 err=0",
                     ctl, state_out, stall_cnt_out, err_out, C_DEF);
        end
        next_cycle();
    endtask

    task automatic test_load_stall();
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out} !== {C_HDU, 2'd0}) begin
            failures++;
            $display("FAIL stall_same_cycle: got ctl=%b st=%0d expected ctl=%b st=0", ctl, state_out, C_HDU);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, stall_cnt_out, err_out} !== {C_DEF, 2'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL stall_next: got ctl=%b st=%0d cnt=%0d err=%b expected ctl=%b st=1 cnt=1 err=0",
                     ctl, state_out, stall_cnt_out, err_out, C_DEF);
        end
        next_cycle();
        @(negedge clk_in);
        checks++;
        if ({state_out, stall_cnt_out} !== {2'd0, 4'd1}) begin
            failures++;
            $display("FAIL stall_back_to_run: got st=%0d cnt=%0d expected st=0 cnt=1", state_out, stall_cnt_out);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b1);
        next_cycle();
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, err_out} !== {C_HDU, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL stall_second: got ctl=%b st=%0d err=%b expected ctl=%b st=1 err=0",
                     ctl, state_out, err_out, C_HDU);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({state_out, stall_cnt_out, err_out} !== {2'd1, 4'd3, 1'b1}) begin
            failures++;
            $display("FAIL stall_err_set: got st=%0d cnt=%0d err=%b expected st=1 cnt=3 err=1",
                     state_out, stall_cnt_out, err_out);
        end
        repeat (3) next_cycle();
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, err_out} !== {C_DEF, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL stall_err_sticky: got ctl=%b st=%0d err=%b expected ctl=%b st=0 err=1",
                     ctl, state_out, err_out, C_DEF);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out} !== {C_BR, 2'd0}) begin
            failures++;
            $display("FAIL branch_c0: got ctl=%b st=%0d expected ctl=%b st=0", ctl, state_out, C_BR);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out} !== {C_FL, 2'd3}) begin
            failures++;
            $display("FAIL branch_c1: got ctl=%b st=%0d expected ctl=%b st=3", ctl, state_out, C_FL);
        end
        next_cycle();
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, stall_cnt_out} !== {C_DEF, 2'd0, 4'd0}) begin
            failures++;
            $display("FAIL branch_c2: got ctl=%b st=%0d cnt=%0d expected ctl=%b st=0 cnt=0",
                     ctl, state_out, stall_cnt_out, C_DEF);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 1), 1'b0);
            @(negedge clk_in);
            checks++;
            if ({ctl, state_out} !== {C_BUSY, (i == 0) ? 2'd0 : 2'd2}) begin
                failures++;
                $display("FAIL memwait_busy%0d: got ctl=%b st=%0d expected ctl=%b st=%0d",
                         i, ctl, state_out, C_BUSY, (i == 0) ? 0 : 2);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, stall_cnt_out} !== {C_BR, 2'd2, 4'd4}) begin
            failures++;
            $display("FAIL memwait_release: got ctl=%b st=%0d cnt=%0d expected ctl=%b st=2 cnt=4",
                     ctl, state_out, stall_cnt_out, C_BR);
        end
        next_cycle();
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out} !== {C_FL, 2'd3}) begin
            failures++;
            $display("FAIL memwait_squash: got ctl=%b st=%0d expected ctl=%b st=3", ctl, state_out, C_FL);
        end
        next_cycle();
    endtask

    task automatic test_branch_hdu();
        do_reset();
        drive(1'b0, 1'b1, 1'b1);
        @(negedge clk_in);
        checks++;
        if (ctl !== C_BR) begin
            failures++;
            $display("FAIL br_hdu_c0: got ctl=%b expected ctl=%b", ctl, C_BR);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        checks++;
        if ({ctl, state_out, err_out} !== {C_FL, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL br_hdu_c1: got ctl=%b st=%0d err=%b expected ctl=%b st=3 err=0",
                     ctl, state_out, err_out, C_FL);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({state_out, err_out, stall_cnt_out} !== {2'd0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL br_hdu_c2: got st=%0d err=%b cnt=%0d expected st=0 err=0 cnt=0",
                     state_out, err_out, stall_cnt_out);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 10) begin
                checks++;
                if (stall_cnt_out !== 4'd10) begin
                    failures++;
                    $display("FAIL sat_mid: got cnt=%0d expected 10", stall_cnt_out);
                end
            end
        end
        @(negedge clk_in);
        checks++;
        if ({stall_cnt_out, state_out} !== {4'd15, 2'd2}) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%0d st=%0d expected cnt=15 st=2", stall_cnt_out, state_out);
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({ctl, state_out, stall_cnt_out} !== {C_RST, 2'd0, 4'd0}) begin
            failures++;
            $display("FAIL sat_async_reset: got ctl=%b st=%0d cnt=%0d expected ctl=%b st=0 cnt=0",
                     ctl, state_out, stall_cnt_out, C_RST);
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        next_cycle();
    endtask

    task automatic test_random();
        int         m_state;
        int         m_squash;
        int         m_cnt;
        bit         m_pend;
        bit         m_err;
        int         n_state;
        bit         n_err;
        logic       b;
        logic       br;
        logic       h;
        logic [4:0] exp_ctl;
        logic [11:0] expv;
        logic [11:0] obsv;
        m_state  = 0;
        m_squash = 0;
        m_cnt    = 0;
        m_pend   = 1'b0;
        m_err    = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) begin
                do_reset();
                m_state  = 0;
                m_squash = 0;
                m_cnt    = 0;
                m_pend   = 1'b0;
                m_err    = 1'b0;
            end
            b  = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 2) == 0);
            drive(b, br, h);
            n_err = m_err;
            if (b) begin
                exp_ctl = C_BUSY;
                n_state = 2;
                if (br) m_pend = 1'b1;
            end else if (br || m_pend) begin
                exp_ctl  = C_BR;
                m_pend   = 1'b0;
                m_squash = FLUSH_DEPTH - 1;
                n_state  = (m_squash > 0) ? 3 : 0;
            end else if (m_squash > 0) begin
                exp_ctl  = C_FL;
                m_squash = m_squash - 1;
                n_state  = (m_squash > 0) ? 3 : 0;
            end else if (h) begin
                exp_ctl = C_HDU;
                if (m_state == 1) n_err = 1'b1;
                n_state = 1;
            end else begin
                exp_ctl = C_DEF;
                n_state = 0;
            end
            expv = {exp_ctl, 2'(m_state), 4'(m_cnt), m_err};
            @(negedge clk_in);
            obsv = {ctl, state_out, stall_cnt_out, err_out};
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL random_cycle%0d (busy=%b br=%b hdu=%b): got ctl=%b st=%0d cnt=%0d err=%b expected ctl=%b st=%0d cnt=%0d err=%b",
                         i, b, br, h, obsv[11:7], obsv[6:5], obsv[4:1], obsv[0],
                         expv[11:7], expv[6:5], expv[4:1], expv[0]);
            end
            if (!exp_ctl[4]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_state = n_state;
            m_err   = n_err;
            next_cycle();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n_in = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_stall();
        test_branch();
        test_mem_wait();
        test_branch_hdu();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
